// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the architectural PC and fetches one instruction at a time over req/gnt/rvalid.
// Each fetched word is held for decode until handshake; a redirect overrides all other events.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready,
  output logic        fetch_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic [2:0]  state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        drop_r, drop_s;
  logic        req_r;
  logic        valid_r, valid_s;
  logic [31:0] inst_r, inst_s;
  logic [31:0] inst_pc_r, inst_pc_s;
  logic        err_r, err_s;

  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  assign imem_req   = req_r;
  assign imem_addr  = pc_r;
  assign inst_valid = valid_r;
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign fetch_err  = err_r;

  // Next-state, PC and decode-output selection; redirect wins over everything else.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    drop_s    = drop_r;
    valid_s   = valid_r;
    inst_s    = inst_r;
    inst_pc_s = inst_pc_r;
    err_s     = err_r;
    if (redirect) begin
      pc_s    = redirect_pc;
      valid_s = 1'b0;
      if (misaligned(redirect_pc)) begin
        state_s = ERR;
        drop_s  = 1'b0;
        err_s   = 1'b1;
      end else begin
        err_s = 1'b0;
        // A request already granted still owes one rvalid, which must be discarded.
        case (state_r)
          REQ: begin
            if (imem_gnt) begin
              state_s = WAIT;
              drop_s  = 1'b1;
            end else begin
              state_s = REQ;
              drop_s  = 1'b0;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              state_s = REQ;
              drop_s  = 1'b0;
            end else begin
              state_s = WAIT;
              drop_s  = 1'b1;
            end
          end
          default: begin
            state_s = REQ;
            drop_s  = 1'b0;
          end
        endcase
      end
    end else begin
      case (state_r)
        IDLE: state_s = REQ;
        REQ: begin
          if (imem_gnt) begin
            state_s = WAIT;
          end else begin
            state_s = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop_r) begin
              drop_s  = 1'b0;
              state_s = REQ;
            end else begin
              inst_s    = imem_rdata;
              inst_pc_s = pc_r;
              valid_s   = 1'b1;
              state_s   = HOLD;
            end
          end else begin
            state_s = WAIT;
          end
        end
        HOLD: begin
          if (valid_r && dec_ready) begin
            pc_s    = npc;
            valid_s = 1'b0;
            if (misaligned(npc)) begin
              state_s = ERR;
              err_s   = 1'b1;
            end else begin
              state_s = REQ;
            end
          end else begin
            state_s = HOLD;
          end
        end
        ERR: begin
          state_s = ERR;
          valid_s = 1'b0;
        end
        default: begin
          state_s = IDLE;
          valid_s = 1'b0;
          drop_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; imem_req is registered from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      pc_r      <= RESET_PC;
      drop_r    <= 1'b0;
      req_r     <= 1'b0;
      valid_r   <= 1'b0;
      inst_r    <= 32'h0000_0000;
      inst_pc_r <= 32'h0000_0000;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      drop_r    <= drop_s;
      req_r     <= (state_s == REQ);
      valid_r   <= valid_s;
      inst_r    <= inst_s;
      inst_pc_r <= inst_pc_s;
      err_r     <= err_s;
    end
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Owns the architectural PC register and fetches instructions from instruction memory over a req/gnt/rvalid interface.
- Presents each fetched instruction to decode with a valid/ready handshake.
- Loads the next-PC value from the next-PC generator when decode consumes the instruction, closing the PC loop the next-PC generator feeds.
- Also accepts an exception/interrupt redirect that overrides the normal flow.

Parameters:
RESET_PC  32'h0000_3000  PC value loaded on reset; first fetch address.

Ports:
clk            input   1   clock, all state on rising edge
rstn           input   1   asynchronous active-low reset
npc            input   32  next PC from next-PC generator, sampled on decode handshake
redirect       input   1   exception/interrupt redirect strobe
redirect_pc    input   32  redirect target
imem_req       output  1   fetch request
imem_addr      output  32  fetch byte address
imem_gnt       input   1   request accepted this cycle
imem_rvalid    input   1   read data valid (exactly one per granted request)
imem_rdata     input   32  instruction word
inst_valid     output  1   instruction available to decode
inst           output  32  instruction word
inst_pc        output  32  PC of inst (feeds next-PC generator PC input)
dec_ready      input   1   decode accepts instruction
fetch_err      output  1   sticky misaligned-PC error

Behaviour:
- Reset (rstn low, asynchronous): pc_q=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, drop=0.
- imem_addr=pc_q at all times. imem_req=1 only in REQ.
- States:
  - IDLE: first cycle after reset release; go to REQ unconditionally.
  - REQ: if imem_gnt, go to WAIT. The address may change while gnt is low (redirect only).
  - WAIT: on imem_rvalid:
    - drop=0: inst<=imem_rdata, inst_pc<=pc_q, inst_valid<=1, go to HOLD.
    - drop=1: discard the data, clear drop, go to REQ.
  - HOLD: inst, inst_pc and inst_valid stay stable until dec_ready.
    - On inst_valid&dec_ready: pc_q<=npc, inst_valid<=0, go to REQ.
  - ERR: imem_req=0, inst_valid=0. Leave only via redirect or reset.
- Misalignment: any value loaded into pc_q (npc or redirect_pc) with bits[1:0]!=0 goes to ERR with fetch_err=1. Exception: a misaligned redirect_pc also goes to ERR.
- Redirect has priority over every other event in the same cycle:
  - pc_q<=redirect_pc, inst_valid<=0, fetch_err<=0 (if aligned).
  - IDLE/REQ without gnt/HOLD/ERR: go to REQ.
  - REQ with imem_gnt same cycle: the old request is in flight; go to WAIT with drop=1.
  - WAIT without rvalid: stay in WAIT with drop=1.
  - WAIT with rvalid same cycle: data discarded, go to REQ, drop=0.
  - Redirect in HOLD with dec_ready same cycle: the handshake is cancelled; npc is ignored.
- Timing: with zero-wait memory (gnt in REQ, rvalid the next cycle) and dec_ready held high, throughput is 1 instruction per 3 cycles. There is exactly one outstanding request.
- npc is used only at the HOLD handshake and is never registered otherwise. Arithmetic on npc is entirely the generator's responsibility; this block does none.
- Reset mid-transaction: all state clears immediately. A late imem_rvalid arriving after reset release, while in IDLE/REQ, is ignored.

Test Plan:
- Reset release, RESET_PC=0x3000, zero-wait memory, dec_ready=1, npc=inst_pc+4 -> imem_addr sequence 0x3000, 0x3004, 0x3008; inst_valid pulses every 3rd cycle; inst matches memory.
- Handshake hold with dec_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, no new imem_req. Then raise dec_ready with npc=0x3040 -> next imem_addr=0x3040.
- imem_gnt delayed 4 cycles and rvalid delayed 3 cycles -> imem_req held high, addr stable; the single instruction is delivered correctly.
- Redirect to 0x0000_4180 in WAIT before rvalid -> the returning word is dropped (inst_valid stays 0); next request addr=0x4180; its data is delivered with inst_pc=0x4180.
- Redirect and dec_ready in the same HOLD cycle, npc=0x3100, redirect_pc=0x4180 -> next addr 0x4180, never 0x3100.
- npc=0x3002 at handshake -> fetch_err=1, imem_req stays 0. Then redirect_pc=0x4180 -> fetch_err=0 and fetch resumes at 0x4180.
